// File: rtl/gf3m_serial_mult.sv
// Bit-serial GF(3^M) multiplier over the trinomial x^M + x^K + 2, one b coefficient per cycle, MSB first.
// Define GF3M_MAC_EN to add port c and an ADD state producing out = a*b + c.
module gf3m_serial_mult #(
  parameter int unsigned M = 97,
  parameter int unsigned K = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2*M-1:0]   a,
  input  logic [2*M-1:0]   b,
`ifdef GF3M_MAC_EN
  input  logic [2*M-1:0]   c,
`endif
  output logic             busy,
  output logic             done,
  output logic [2*M-1:0]   out
);

  localparam int unsigned W  = 2 * M;
  localparam int unsigned CW = (M > 1) ? $clog2(M) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
`ifdef GF3M_MAC_EN
  localparam logic [1:0] ADD  = 2'd2;
`endif

  // Coefficient helpers; operands are pre-normalised so 11 never reaches add3.
  function automatic logic [1:0] norm3(input logic [1:0] x);
    return (x == 2'b11) ? 2'b00 : x;
  endfunction

  function automatic logic [1:0] add3(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  function automatic logic [1:0] mul3(input logic [1:0] x, input logic [1:0] y);
    logic [1:0] r;
    case ({x, y})
      4'b0101: r = 2'd1;
      4'b0110: r = 2'd2;
      4'b1001: r = 2'd2;
      4'b1010: r = 2'd1;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  function automatic logic [W-1:0] norm_vec(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < M; i++) r[2*i +: 2] = norm3(v[2*i +: 2]);
    return r;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  out_q, out_d;
  logic          done_q, done_d;
`ifdef GF3M_MAC_EN
  logic [W-1:0]  c_q, c_d;
  logic [W-1:0]  acc_plus_c;
`endif

  logic [1:0]    top_coef;
  logic [1:0]    b_coef;
  logic [W-1:0]  acc_shift;
  logic [W-1:0]  acc_next;

  // acc*x mod P: shift up one coefficient, fold the outgoing one back as 2t at x^K and t at x^0.
  always_comb begin
    top_coef  = acc_q[W-1 -: 2];
    acc_shift = {acc_q[W-3:0], 2'b00};
    acc_shift[2*K +: 2] = add3(acc_shift[2*K +: 2], mul3(2'd2, top_coef));
    acc_shift[1:0]      = add3(acc_shift[1:0], top_coef);
  end

  always_comb begin
    b_coef   = b_q[{cnt_q, 1'b0} +: 2];
    acc_next = '0;
    for (int unsigned i = 0; i < M; i++) begin
      acc_next[2*i +: 2] = add3(acc_shift[2*i +: 2], mul3(b_coef, a_q[2*i +: 2]));
    end
  end

`ifdef GF3M_MAC_EN
  always_comb begin
    acc_plus_c = '0;
    for (int unsigned i = 0; i < M; i++) begin
      acc_plus_c[2*i +: 2] = add3(acc_q[2*i +: 2], c_q[2*i +: 2]);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    done_d  = 1'b0;
`ifdef GF3M_MAC_EN
    c_d     = c_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = norm_vec(a);
          b_d     = norm_vec(b);
`ifdef GF3M_MAC_EN
          c_d     = norm_vec(c);
`endif
          acc_d   = '0;
          cnt_d   = CW'(M - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_next;
        if (cnt_q == '0) begin
`ifdef GF3M_MAC_EN
          state_d = ADD;
`else
          out_d   = acc_next;
          done_d  = 1'b1;
          state_d = IDLE;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef GF3M_MAC_EN
      ADD: begin
        out_d   = acc_plus_c;
        done_d  = 1'b1;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
`ifdef GF3M_MAC_EN
      c_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      done_q  <= done_d;
`ifdef GF3M_MAC_EN
      c_q     <= c_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign out  = out_q;

endmodule

// File: tb/tb_gf3m_serial_mult.sv
// Scoreboard bench for gf3m_serial_mult (M=97, K=12): stimulus pushes hand-computed results, a monitor checks on done.
module tb_gf3m_serial_mult;

  localparam int unsigned M = 97;
  localparam int unsigned K = 12;
  localparam int unsigned W = 2 * M;
`ifdef GF3M_MAC_EN
  localparam int unsigned LAT = M + 1;
`else
  localparam int unsigned LAT = M;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] c;
  logic         busy;
  logic         done;
  logic [W-1:0] out;

  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    string        name;
    logic [W-1:0] val;
    int unsigned  when;
  } exp_t;
  exp_t exp_q[$];

  gf3m_serial_mult #(.M(M), .K(K)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef GF3M_MAC_EN
    .c     (c),
`endif
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] mono(input int unsigned i, input logic [1:0] v);
    logic [W-1:0] r;
    r = '0;
    r[2*i +: 2] = v;
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Called at a negedge; the next posedge samples start.
  task automatic issue(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] cv, input logic [W-1:0] ev);
    exp_t e;
    start = 1'b1;
    a = av;
    b = bv;
    c = cv;
    e.name = name;
    e.val  = ev;
    e.when = cyc + 1 + LAT;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = '1;
    b = '1;
    c = '1;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * LAT + 10; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got done=0 required done=1", name);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at cycle %0d: got done=1 required done=0", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.name, out, e.val);
        check({e.name, "_latency"}, W'(cyc), W'(e.when));
        check({e.name, "_busy_low"}, W'(busy), W'(0));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    c = '0;
    repeat (3) @(negedge clk);
    check("reset_out", out, '0);
    check("reset_busy", W'(busy), W'(0));
    check("reset_done", W'(done), W'(0));
    reset = 1'b0;
    @(negedge clk);

    // 1*1: busy every cycle until the result appears
    issue("one_times_one", mono(0, 1), mono(0, 1), '0, mono(0, 1));
    repeat (LAT - 1) begin
      check("one_busy_high", W'({busy, done}), W'(2'b10));
      @(negedge clk);
    end
    wait_done("one_times_one");
    @(negedge clk);

    issue("x_times_x96", mono(1, 1), mono(96, 1), '0, mono(12, 2) | mono(0, 1));
    wait_done("x_times_x96");
    @(negedge clk);

    issue("two_times_two", mono(0, 2), mono(0, 2), '0, mono(0, 1));
    wait_done("two_times_two");
    @(negedge clk);

    issue("all_11_is_zero", '1, mono(0, 1), '0, '0);
    wait_done("all_11_is_zero");
    @(negedge clk);

    // x^100 = x^3 * (2x^12 + 1)
    issue("x50_sq", mono(50, 1), mono(50, 1), '0, mono(15, 2) | mono(3, 1));
    wait_done("x50_sq");
    @(negedge clk);

    // x^192 = x^95 + 2x^107, x^107 = 2x^22 + x^10
    issue("x96_sq", mono(96, 1), mono(96, 1), '0, mono(95, 1) | mono(22, 1) | mono(10, 2));
    wait_done("x96_sq");
    @(negedge clk);

    issue("poly_times_two", mono(0, 1) | mono(1, 1) | mono(5, 2), mono(0, 2), '0,
          mono(0, 2) | mono(1, 2) | mono(5, 1));
    wait_done("poly_times_two");
    @(negedge clk);

    // Second start while busy must be ignored
    issue("start_while_busy", mono(0, 2), mono(0, 2), '0, mono(0, 1));
    repeat (9) @(negedge clk);
    start = 1'b1;
    a = mono(1, 1);
    b = mono(96, 1);
    @(negedge clk);
    start = 1'b0;
    wait_done("start_while_busy");
    repeat (LAT + 5) @(negedge clk);

    // Reset mid-run: no result expected for the aborted operation
    start = 1'b1;
    a = mono(3, 1);
    b = mono(0, 1);
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_out", out, '0);
    check("abort_busy", W'(busy), W'(0));
    reset = 1'b0;
    @(negedge clk);
    issue("after_reset_x_sq", mono(1, 1), mono(1, 1), '0, mono(2, 1));
    wait_done("after_reset_x_sq");
    @(negedge clk);

    // Back-to-back: start accepted on the done cycle
`ifdef GF3M_MAC_EN
    issue("mac_one_plus_two", mono(0, 1), mono(0, 1), mono(0, 2), '0);
    wait_done("mac_one_plus_two");
    issue("mac_back_to_back", mono(0, 2), mono(1, 1), mono(0, 1), mono(1, 2) | mono(0, 1));
    wait_done("mac_back_to_back");
`else
    issue("b2b_first", mono(1, 1), mono(96, 1), '0, mono(12, 2) | mono(0, 1));
    wait_done("b2b_first");
    issue("b2b_second", mono(0, 2), mono(1, 1), '0, mono(1, 2));
    wait_done("b2b_second");
`endif
    repeat (5) @(negedge clk);
    check("pending_results", W'(exp_q.size()), W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
